sr_latch_driver: RTL and testbench

- Clocked front end that drives the s/r inputs of an sr_latch instance.
- Accepts "set latch to value v" requests over a valid/ready handshake and converts each into one clean pulse: s for v=1, r for v=0.
- Never asserts s and r together (the forbidden latch input).
- Reads back q/qbar, checks that the latch took the value, retries on failure and flags a sticky error after repeated failures.

---
 rtl/sr_latch_driver.sv | 177 +++++++++++++++++
 tb/tb_sr_latch_driver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked front end for an SR latch. Turns each accepted
// "set latch to v" request into a clean s or r pulse, waits a gap, verifies
// q/qbar, retries up to MAX_RETRY times and raises a sticky err on give-up.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/req_val  request handshake in, target value
//   req_ready          high while idle and able to accept
//   s, r               registered latch drives, never high together
//   q_fb, qbar_fb      latch read-back, sampled in CHECK
//   done               one-cycle pulse on a verified request
//   err                sticky, set when retries are exhausted
//   busy               request in progress
//
// Optional: define SR_DRV_SKIP_EN to complete a request immediately
// (no pulse) when the latch already holds the requested value.
module sr_latch_driver #(
   parameter int PULSE_W   = 2,
   parameter int GAP_W     = 1,
   parameter int MAX_RETRY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_val,
   output logic req_ready,
   output logic s,
   output logic r,
   input  logic q_fb,
   input  logic qbar_fb,
   output logic done,
   output logic err,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP,
      CHECK
   } state_t;

   localparam logic [3:0] PW = 4'(PULSE_W);
   localparam logic [3:0] GW = 4'(GAP_W);
   localparam logic [2:0] MR = 3'(MAX_RETRY);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] att_q, att_d;
   logic       tgt_q, tgt_d;
   logic       s_q, s_d;
   logic       r_q, r_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;
   logic       skip_q, skip_d;

   logic       accept;
   logic       fb_ok;
   logic       skip_hit;

`ifdef SR_DRV_SKIP_EN
   assign skip_hit = (q_fb == req_val) && (qbar_fb == ~req_val);
`else
   assign skip_hit = 1'b0;
`endif

   // skip_q blocks a new accept during the done cycle of a skipped request
   assign req_ready = (state_q == IDLE) && !skip_q;
   assign accept    = req_valid && req_ready;
   // q_fb == qbar_fb can never satisfy both terms, so it counts as a fail
   assign fb_ok     = (q_fb == tgt_q) && (qbar_fb == ~tgt_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      att_d   = att_q;
      tgt_d   = tgt_q;
      s_d     = s_q;
      r_d     = r_q;
      done_d  = 1'b0;
      err_d   = err_q;
      busy_d  = busy_q;
      skip_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_d = req_val;
               if (skip_hit) begin
                  done_d = 1'b1;
                  skip_d = 1'b1;
               end else begin
                  state_d = DRIVE;
                  cnt_d   = PW;
                  att_d   = 3'd0;
                  s_d     = req_val;
                  r_d     = ~req_val;
                  busy_d  = 1'b1;
               end
            end
         end
         DRIVE: begin
            if (cnt_q == 4'd1) begin
               state_d = GAP;
               cnt_d   = GW;
               s_d     = 1'b0;
               r_d     = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         GAP: begin
            if (cnt_q == 4'd1) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CHECK: begin
            if (fb_ok) begin
               state_d = IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (att_q == MR) begin
               state_d = IDLE;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = DRIVE;
               att_d   = att_q + 3'd1;
               cnt_d   = PW;
               s_d     = tgt_q;
               r_d     = ~tgt_q;
            end
         end
         default: begin
            state_d = IDLE;
            s_d     = 1'b0;
            r_d     = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         att_q   <= 3'd0;
         tgt_q   <= 1'b0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         att_q   <= att_d;
         tgt_q   <= tgt_d;
         s_q     <= s_d;
         r_q     <= r_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         skip_q  <= skip_d;
      end
   end

   assign s    = s_q;
   assign r    = r_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: randomized bench with a cycle-indexed expectation
// table built from the request rules and an SR latch model on s/r.
module tb_sr_latch_driver;

   localparam int PW = 2;
   localparam int GW = 1;
   localparam int MR = 3;
   localparam int N  = 8192;
   localparam int BIG = 1 << 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0;
   logic req_val = 1'b0;
   logic req_ready, s, r, done, err, busy;
   logic q_fb, qbar_fb;

   logic lq = 1'b0;
   logic ovr_en = 1'b0;
   logic ovr_q = 1'b0;
   logic ovr_qb = 1'b0;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   bit es [N];
   bit er [N];
   bit ed [N];
   bit eb [N];
   bit erdy [N];
   int err_from = BIG;

   int s_cyc = 0, r_cyc = 0, s_rise = 0, done_cnt = 0;
   int last_done = -1;
   bit s_prev = 1'b0;

   sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .MAX_RETRY(MR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_val(req_val), .req_ready(req_ready),
      .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
      .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge s or posedge r) lq <= s;
   assign q_fb    = ovr_en ? ovr_q  : lq;
   assign qbar_fb = ovr_en ? ovr_qb : ~lq;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask

   always @(s or r) begin
      if (s && r) begin
         n_fail++;
         $display("FAIL s_and_r_async cyc=%0d got=1 want=0", cyc);
      end
   end

   always @(negedge clk) begin
      if (chk_on && cyc < N) begin
         chk("s", int'(s), int'(es[cyc]));
         chk("r", int'(r), int'(er[cyc]));
         chk("done", int'(done), int'(ed[cyc]));
         chk("busy", int'(busy), int'(eb[cyc]));
         chk("req_ready", int'(req_ready), int'(erdy[cyc]));
         chk("err", int'(err), int'(cyc >= err_from));
         chk("s_and_r", int'(s & r), 0);
      end
      if (s) s_cyc++;
      if (r) r_cyc++;
      if (s && !s_prev) s_rise++;
      s_prev = s;
      if (done) begin
         done_cnt++;
         last_done = cyc;
      end
   end

   // Fill expected outputs for a request accepted at edge k; returns the
   // last cycle of the request (done or err cycle).
   function automatic int plan(input bit v, input int mode, input bit sv,
                               input bit skip, input int k);
      int idx = k;
      bit pass;
      if (skip) begin
         ed[k] = 1'b1;
         erdy[k] = 1'b0;
         return k;
      end
      for (int a = 0; a <= MR; a++) begin
         for (int i = 0; i < PW + GW + 1; i++) begin
            es[idx] = (i < PW) ? v : 1'b0;
            er[idx] = (i < PW) ? ~v : 1'b0;
            eb[idx] = 1'b1;
            erdy[idx] = 1'b0;
            idx++;
         end
         case (mode)
            0: pass = 1'b1;
            1: pass = (v == sv);
            2: pass = (a > 0);
            default: pass = 1'b0;
         endcase
         if (pass) begin
            ed[idx] = 1'b1;
            return idx;
         end
      end
      if (err_from > idx) err_from = idx;
      return idx;
   endfunction

   function automatic bit skip_now(input bit v);
`ifdef SR_DRV_SKIP_EN
      return (q_fb == v) && (qbar_fb == ~v);
`else
      return 1'b0;
`endif
   endfunction

   // mode: 0 latch follows, 1 stuck at sv, 2 fail first check, 3 q==qbar
   task automatic do_req(input bit v, input int mode, input bit sv,
                         output int k);
      int last, wend, rel;
      bit sk;
      k = cyc + 1;
      ovr_en = (mode != 0);
      ovr_q  = (mode == 3) ? 1'b1 : (mode == 2) ? ~v : sv;
      ovr_qb = (mode == 3) ? 1'b1 : ~ovr_q;
      #0;
      sk = skip_now(v);
      last = plan(v, mode, sv, sk, k);
      wend = sk ? k + 1 : last;
      rel = k + PW + GW + 1;
      req_val = v;
      req_valid = 1'b1;
      while (cyc < wend) begin
         @(negedge clk);
         if (cyc == k) req_valid = 1'b0;
         if (mode == 2 && cyc == rel) ovr_en = 1'b0;
      end
      ovr_en = 1'b0;
      #1;
   endtask

   initial begin
      int k, s0, r0, sr0, d0, last;
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int k, s0, r0, sr0, d0, last;
      for (int i = 0; i < N; i++) erdy[i] = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_s", int'(s), 0);
      chk("rst_r", int'(r), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(req_ready), 1);
      rst = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);

      s0 = s_cyc; r0 = r_cyc;
      do_req(1'b1, 0, 1'b0, k);
      chk("lat_first", last_done - k, 4);
      chk("s_cycles_first", s_cyc - s0, 2);
      chk("r_cycles_first", r_cyc - r0, 0);

      r0 = r_cyc; s0 = s_cyc;
      do_req(1'b0, 0, 1'b0, k);
      chk("b2b_accept", k, last_done - 4);
      chk("r_cycles_b2b", r_cyc - r0, 2);
      chk("s_cycles_b2b", s_cyc - s0, 0);

      sr0 = s_rise;
      do_req(1'b1, 2, 1'b0, k);
      chk("lat_retry", last_done - k, 8);
      chk("s_pulses_retry", s_rise - sr0, 2);
      chk("err_after_retry", int'(err), 0);

      sr0 = s_rise; d0 = done_cnt;
      do_req(1'b1, 1, 1'b0, k);
      chk("s_pulses_stuck", s_rise - sr0, 1 + MR);
      chk("done_stuck", done_cnt - d0, 0);
      chk("err_stuck", int'(err), 1);
      chk("busy_stuck", int'(busy), 0);

      d0 = done_cnt;
      do_req(1'b0, 1, 1'b0, k);
      chk("done_with_err", done_cnt - d0, 1);
      chk("err_sticky", int'(err), 1);

      do_req(1'b0, 3, 1'b0, k);

      d0 = done_cnt;
      k = cyc + 1;
      last = plan(1'b1, 0, 1'b0, skip_now(1'b1), k);
      req_val = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_s", int'(s), 0);
      chk("rst_async_r", int'(r), 0);
      for (int i = cyc; i < cyc + 32; i++) begin
         es[i] = 1'b0; er[i] = 1'b0; ed[i] = 1'b0;
         eb[i] = 1'b0; erdy[i] = 1'b1;
      end
      err_from = BIG;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("ready_after_rst", int'(req_ready), 1);
      chk("done_after_rst", done_cnt - d0, 0);
      chk("err_after_rst", int'(err), 0);

      do_req(1'b1, 0, 1'b0, k);
      s0 = s_cyc;
      do_req(1'b1, 0, 1'b0, k);
`ifdef SR_DRV_SKIP_EN
      chk("lat_skip", last_done - k, 0);
      chk("s_cycles_skip", s_cyc - s0, 0);
`else
      chk("lat_noskip", last_done - k, 4);
      chk("s_cycles_noskip", s_cyc - s0, 2);
`endif

      for (int n = 0; n < 150; n++) begin
         int md;
         md = int'($urandom_range(0, 9));
         md = (md < 5) ? 0 : (md < 7) ? 1 : (md < 9) ? 2 : 3;
         do_req(1'($urandom_range(0, 1)), md, 1'($urandom_range(0, 1)), k);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         #1;
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
